// File: rtl/dtc_tx_sched.sv
// rtl/dtc_tx_sched.sv - round-robin byte scheduler feeding the DTC 8:1 output serializer
module dtc_tx_sched #(
    parameter int          NREQ      = 3,
    parameter logic [7:0]  IDLE_BYTE = 8'hBC,
    parameter logic [4:0]  HDR_TAG   = 5'b10100
) (
    input  logic                bitclk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          dtc_pdin,
    output logic                busy,
    output logic [2:0]          cur_ch,
    output logic [7:0]          underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  phase;
    logic [2:0]  last_gnt;

    // Request vectors widened to the full 3-bit channel space so the
    // granted lane can be selected directly by cur_ch for any NREQ.
    logic [7:0]  valid_ext;
    logic [7:0]  last_ext;
    logic [63:0] data_ext;

    logic        slot_edge;
    logic        in_pkt;
    logic        gnt_valid;
    logic        gnt_last;
    logic [7:0]  gnt_byte;

    logic        arb_found;
    logic [2:0]  arb_ch;
    logic [3:0]  cand;

    assign valid_ext = 8'(req_valid);
    assign last_ext  = 8'(req_last);
    assign data_ext  = 64'(req_data);

    // The serializer loads dtc_pdin on the edge ending phase 7, so every
    // update is made one edge earlier to keep the byte stable through phase 7.
    assign slot_edge = (phase == 3'd6);
    assign in_pkt    = (state != ST_IDLE);

    assign gnt_valid = valid_ext[cur_ch];
    assign gnt_last  = last_ext[cur_ch];
    assign gnt_byte  = data_ext[{cur_ch, 3'b000} +: 8];

    // Free-running frame phase, aligned with the serializer bit counter
    always_ff @(posedge bitclk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= 3'd0;
        end else begin
            phase <= phase + 3'd1;
        end
    end

    // Round-robin search starting just after the last granted channel;
    // scanning farthest-first lets the nearest valid candidate win.
    always_comb begin
        arb_found = 1'b0;
        arb_ch    = 3'd0;
        cand      = 4'd0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = {1'b0, last_gnt} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            if (valid_ext[cand[2:0]]) begin
                arb_found = 1'b1;
                arb_ch    = cand[2:0];
            end
        end
    end

    // Ready strobes only the granted source, only in the slot-edge cycle
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = slot_edge && in_pkt && (cur_ch == 3'(i));
        end
    end

    // Packet FSM: arbitration, header insertion, payload and underrun fill
    always_ff @(posedge bitclk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            dtc_pdin     <= IDLE_BYTE;
            busy         <= 1'b0;
            cur_ch       <= 3'd0;
            last_gnt     <= 3'(NREQ - 1);
            underrun_cnt <= 8'd0;
        end else if (slot_edge) begin
            case (state)
                ST_IDLE: begin
                    if (enable && arb_found) begin
                        cur_ch   <= arb_ch;
                        last_gnt <= arb_ch;
                        dtc_pdin <= {HDR_TAG, arb_ch};
                        busy     <= 1'b1;
                        state    <= ST_HDR;
                    end else begin
                        dtc_pdin <= IDLE_BYTE;
                    end
                end
                // The header is on the wire during HDR, so the first
                // payload byte is taken at the HDR slot edge already.
                ST_HDR, ST_DATA: begin
                    if (gnt_valid) begin
                        dtc_pdin <= gnt_byte;
                        if (gnt_last) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else begin
                        dtc_pdin <= IDLE_BYTE;
                        state    <= ST_DATA;
                        if (underrun_cnt != 8'hFF) begin
                            underrun_cnt <= underrun_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    dtc_pdin <= IDLE_BYTE;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
